ex_mem_pipe_reg: RTL
====================

Name: ex_mem_pipe_reg

Overview:
- EX/MEM pipeline register for the 16-bit pipelined processor; sits between the execute stage and the memory stage, and drives the memory stage's address, store data, MemR/MemW and WB select.
- Supports stall (hold), flush (bubble insertion), a valid bit that gates memory side effects, and forwarding/hazard taps for the forwarding and hazard units.
- Holds saturating occupancy counters and a sticky error flag for debug.

Parameters:
- DATA_W, 16, datapath width (ALU result, store data)
- REG_ADDR_W, 3, destination register index width
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold current contents (from hazard unit)
- flush  in  1  replace contents with a bubble next edge
- ex_valid  in  1  EX holds a real instruction
- ex_alu_out  in  DATA_W  ALU result / memory address
- ex_store_data  in  DATA_W  rt value for stores
- ex_mem_r  in  1  load
- ex_mem_w  in  1  store
- ex_wb_sel  in  1  1 = write back memory data, 0 = ALU result
- ex_reg_write  in  1  instruction writes the register file
- ex_rd  in  REG_ADDR_W  destination register
- cnt_clear  in  1  synchronous clear of both counters
- mem_address  out  DATA_W  to memory stage Address
- mem_data_in  out  DATA_W  to memory stage DataIn
- mem_r  out  1  gated load strobe
- mem_w  out  1  gated store strobe
- mem_wb_sel  out  1  to memory stage WB select
- mem_reg_write  out  1  gated, passes on to MEM/WB
- mem_rd  out  REG_ADDR_W  passes on to MEM/WB
- mem_valid  out  1  stage holds a real instruction
- fwd_data  out  DATA_W  ALU result available for EX forwarding
- fwd_load  out  1  MEM-stage instruction is a valid load (forwarding of fwd_data is illegal)
- retired_cnt  out  CNT_W  valid instructions accepted
- bubble_cnt  out  CNT_W  bubbles accepted
- err_sticky  out  1  illegal control combination seen

Behaviour:
- All state updates on the rising edge of clk. No combinational path from inputs to outputs; latency is exactly 1 cycle.
- Priority per edge: reset > flush > stall > load.
- reset: every stored field, mem_valid, both counters and err_sticky become 0. All outputs read 0 in the following cycle. Reset mid-stall or mid-flush is identical to reset alone.
- flush=1 (reset=0): valid<=0 and every stored data and control field <=0. Flush overrides a simultaneous stall.
- stall=1 (flush=0): all fields, valid and counters hold. The gated strobes remain asserted if valid, so the memory stage repeats the same access. A repeated read has no side effect; a repeated write rewrites the same data.
- load (stall=0, flush=0): fields capture the ex_* inputs and valid<=ex_valid.
- Illegal: ex_valid & ex_mem_r & ex_mem_w at a load edge is captured as a bubble (valid=0, fields zero) and sets err_sticky. err_sticky clears only on reset.
- Gating: mem_r, mem_w and mem_reg_write each equal the stored bit AND valid. mem_address, mem_data_in, mem_wb_sel and mem_rd are the raw stored values.
- Forwarding taps:
  - fwd_data = stored ALU result.
  - fwd_load = stored mem_r AND valid.
  - The hazard unit uses fwd_load, mem_rd and mem_reg_write.
- Counters:
  - retired_cnt +1 on each load edge that captures a valid, legal instruction.
  - bubble_cnt +1 on each flush edge, and on each load edge capturing valid=0, including illegal captures.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - cnt_clear zeroes both counters. If cnt_clear coincides with an increment event, clear wins.
  - Counters do not change during stall.

Decomposition:
- Shared package `pipe_pkg`:
  - DATA_W and REG_ADDR_W constants.
  - ex_mem_ctrl_t struct {mem_r, mem_w, wb_sel, reg_write, rd}, reused by the ID/EX and MEM/WB registers.
  - A BUBBLE_CTRL constant (all zero).
- One sub-module: `sat_counter` (parameter CNT_W; ports clk, reset, clr, inc, count), instantiated twice.

Test Plan:
- Reset then load: reset 2 cycles, then load valid ex_alu_out=16'h0040, ex_mem_r=1, ex_rd=3 -> after 1 edge mem_address=16'h0040, mem_r=1, fwd_load=1, mem_rd=3, retired_cnt=1.
- Stall hold: valid store addr 16'h0010 data 16'hBEEF, then stall=1 for 3 cycles with new ex inputs -> outputs unchanged, mem_w=1 each cycle, retired_cnt stays 1.
- Flush over stall: stall=1 and flush=1 together -> next cycle mem_valid=0, mem_r=mem_w=mem_reg_write=0, mem_address=0, bubble_cnt +1.
- Illegal combo: ex_valid=1, ex_mem_r=1, ex_mem_w=1 -> mem_valid=0, err_sticky=1. err_sticky stays 1 over 10 following valid loads until reset.
- Saturation and clear: CNT_W=4, 20 valid loads -> retired_cnt=15. cnt_clear together with a valid load -> retired_cnt=0.
- Invalid passthrough: ex_valid=0, ex_reg_write=1, ex_rd=5 -> mem_reg_write=0, mem_rd=5, bubble_cnt +1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths and the control bundle
// carried from EX through MEM towards write-back.
package pipe_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef struct packed {
        logic                  mem_r;
        logic                  mem_w;
        logic                  wb_sel;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } ex_mem_ctrl_t;

    localparam ex_mem_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; reset and clear both zero it, and clear
// beats a simultaneous increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with stall, flush, valid-gated memory strobes,
// forwarding/hazard taps, occupancy counters and a sticky illegal-control flag.
module ex_mem_pipe_reg #(
    parameter int DATA_W     = pipe_pkg::DATA_W,
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_alu_out,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic                  ex_mem_r,
    input  logic                  ex_mem_w,
    input  logic                  ex_wb_sel,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  cnt_clear,
    output logic [DATA_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_data_in,
    output logic                  mem_r,
    output logic                  mem_w,
    output logic                  mem_wb_sel,
    output logic                  mem_reg_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     fwd_data,
    output logic                  fwd_load,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic                  err_sticky
);

    import pipe_pkg::*;

    localparam int CTRL_RD_W = $bits(ex_mem_ctrl_t) - 4;

    logic               valid_q;
    logic [DATA_W-1:0]  alu_q;
    logic [DATA_W-1:0]  store_q;
    ex_mem_ctrl_t       ctrl_q;
    ex_mem_ctrl_t       ctrl_d;
    logic               err_q;

    logic               load;
    logic               illegal;
    logic               retired_inc;
    logic               bubble_inc;

    always_comb begin
        ctrl_d           = BUBBLE_CTRL;
        ctrl_d.mem_r     = ex_mem_r;
        ctrl_d.mem_w     = ex_mem_w;
        ctrl_d.wb_sel    = ex_wb_sel;
        ctrl_d.reg_write = ex_reg_write;
        ctrl_d.rd        = CTRL_RD_W'(ex_rd);
    end

    assign load        = !flush && !stall;
    assign illegal     = ex_valid && ex_mem_r && ex_mem_w;
    assign retired_inc = load && ex_valid && !illegal;
    // Illegal captures are stored as bubbles, so they count as bubbles too.
    assign bubble_inc  = flush || (load && (!ex_valid || illegal));

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            store_q <= '0;
            ctrl_q  <= BUBBLE_CTRL;
            err_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            store_q <= '0;
            ctrl_q  <= BUBBLE_CTRL;
        end else if (!stall) begin
            if (illegal) begin
                valid_q <= 1'b0;
                alu_q   <= '0;
                store_q <= '0;
                ctrl_q  <= BUBBLE_CTRL;
                err_q   <= 1'b1;
            end else begin
                valid_q <= ex_valid;
                alu_q   <= ex_alu_out;
                store_q <= ex_store_data;
                ctrl_q  <= ctrl_d;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_retired_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clear),
        .inc   (retired_inc),
        .count (retired_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clear),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    assign mem_address   = alu_q;
    assign mem_data_in   = store_q;
    assign mem_r         = ctrl_q.mem_r && valid_q;
    assign mem_w         = ctrl_q.mem_w && valid_q;
    assign mem_wb_sel    = ctrl_q.wb_sel;
    assign mem_reg_write = ctrl_q.reg_write && valid_q;
    assign mem_rd        = REG_ADDR_W'(ctrl_q.rd);
    assign mem_valid     = valid_q;
    assign fwd_data      = alu_q;
    assign fwd_load      = ctrl_q.mem_r && valid_q;
    assign err_sticky    = err_q;

endmodule
